// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths, constants and fetch FSM encodings
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_WORD   = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HELD = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_ctrl_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module ifid_reg
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  ifid_ctrl_t      ctrl,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else begin
      case (ctrl)
        IFID_LOAD: begin
          pc    <= load_pc;
          instr <= load_instr;
          valid <= 1'b1;
        end
        // A bubble keeps the PC it would have carried, so debug traces stay ordered.
        IFID_BUBBLE: begin
          pc    <= load_pc;
          instr <= NOP_INSTR;
          valid <= 1'b0;
        end
        default: begin
          pc    <= pc;
          instr <= instr;
          valid <= valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, REQ/HELD FSM, hold buffer, optional FETCH_PERF_COUNT_EN counters
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            IFIDWrite,
  input  logic            Flush,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_Instr,
  output logic            IFID_Valid,
  output logic [XLEN-1:0] stall_count,
  output logic [XLEN-1:0] flush_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_pc_q, buf_instr_q;
  logic            buf_load;
  logic            stall;
  ifid_ctrl_t      ifid_ctrl;
  logic [XLEN-1:0] ifid_load_pc, ifid_load_instr;

  assign stall     = !(PCWrite && IFIDWrite);
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == FETCH_REQ) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_REQ;
      pc_q        <= RESET_PC;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (buf_load) begin
        buf_pc_q    <= pc_q;
        buf_instr_q <= imem_rdata;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_load        = 1'b0;
    ifid_ctrl       = IFID_HOLD;
    ifid_load_pc    = pc_q;
    ifid_load_instr = imem_rdata;

    // Flush beats stall and drops any response or buffered word this cycle.
    if (Flush) begin
      ifid_ctrl = IFID_BUBBLE;
      pc_d      = jump_target;
      state_d   = FETCH_REQ;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (imem_ready) begin
            if (!stall) begin
              ifid_ctrl = IFID_LOAD;
              pc_d      = pc_next(pc_q);
            end else begin
              buf_load = 1'b1;
              state_d  = FETCH_HELD;
            end
          end else if (!stall) begin
            ifid_ctrl = IFID_BUBBLE;
          end
        end
        FETCH_HELD: begin
          if (!stall) begin
            ifid_ctrl       = IFID_LOAD;
            ifid_load_pc    = buf_pc_q;
            ifid_load_instr = buf_instr_q;
            pc_d            = pc_next(pc_q);
            state_d         = FETCH_REQ;
          end
        end
        default: state_d = FETCH_REQ;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ifid_ctrl),
    .load_pc   (ifid_load_pc),
    .load_instr(ifid_load_instr),
    .pc        (IFID_PC),
    .instr     (IFID_Instr),
    .valid     (IFID_Valid)
  );

`ifdef FETCH_PERF_COUNT_EN
  logic [XLEN-1:0] stall_count_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (stall && !Flush) stall_count_q <= stall_count_q + 32'd1;
      if (Flush)           flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: directed table, corner sequences, randomized vs reference model
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PCWrite, IFIDWrite, Flush, imem_ready, imem_req, IFID_Valid;
  logic [31:0] jump_target, imem_addr, imem_rdata, IFID_PC, IFID_Instr;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Reference model state, advanced once per rising edge from the behavioural rules.
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_held_pc, m_held_word, m_stalls, m_flushes;
  bit          m_ifid_valid, m_held, m_rst;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCWrite    (PCWrite),
    .IFIDWrite  (IFIDWrite),
    .Flush      (Flush),
    .jump_target(jump_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .IFID_PC    (IFID_PC),
    .IFID_Instr (IFID_Instr),
    .IFID_Valid (IFID_Valid),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit pw, input bit iw, input bit fl,
                            input logic [31:0] jt, input bit rdy);
    bit st;
    st    = !(pw && iw);
    m_rst = r;
    if (r) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 0;
      m_held = 0; m_stalls = 0; m_flushes = 0;
    end else if (fl) begin
      m_ifid_pc = m_pc; m_ifid_instr = NOP; m_ifid_valid = 0;
      m_pc = jt; m_held = 0; m_flushes++;
    end else begin
      if (st) m_stalls++;
      if (m_held) begin
        if (!st) begin
          m_ifid_pc = m_held_pc; m_ifid_instr = m_held_word; m_ifid_valid = 1;
          m_pc = m_pc + 32'd4; m_held = 0;
        end
      end else if (rdy && !st) begin
        m_ifid_pc = m_pc; m_ifid_instr = mem_word(m_pc); m_ifid_valid = 1;
        m_pc = m_pc + 32'd4;
      end else if (rdy) begin
        m_held = 1; m_held_pc = m_pc; m_held_word = mem_word(m_pc);
      end else if (!st) begin
        m_ifid_pc = m_pc; m_ifid_instr = NOP; m_ifid_valid = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("imem_req", {31'b0, imem_req}, {31'b0, !m_held && !m_rst});
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_pc", IFID_PC, m_ifid_pc);
    chk("ifid_instr", IFID_Instr, m_ifid_instr);
    chk("ifid_valid", {31'b0, IFID_Valid}, {31'b0, m_ifid_valid});
`ifdef FETCH_PERF_COUNT_EN
    chk("stall_count", stall_count, m_stalls);
    chk("flush_count", flush_count, m_flushes);
`else
    chk("stall_count", stall_count, 32'h0);
    chk("flush_count", flush_count, 32'h0);
`endif
  endtask

  task automatic cycle(input bit r, input bit pw, input bit iw, input bit fl,
                       input logic [31:0] jt, input bit rdy);
    rst = r; PCWrite = pw; IFIDWrite = iw; Flush = fl; jump_target = jt; imem_ready = rdy;
    imem_rdata = rdy ? mem_word(m_pc) : $urandom;
    @(posedge clk);
    model_step(r, pw, iw, fl, jt, rdy);
    #1;
    check_model();
  endtask

  typedef struct {
    bit          rst, pw, iw, fl, rdy;
    logic [31:0] jt;
    logic [31:0] e_pc;
    bit          e_valid;
    logic [31:0] e_addr;
    bit          e_req;
  } vec_t;

  vec_t tbl[25];

  initial begin
    // rst pw iw fl rdy jt | IFID_PC valid imem_addr imem_req
    tbl[0]  = '{1, 1, 1, 0, 1, 32'h0,   32'h0,   0, 32'h0,   0};
    tbl[1]  = '{0, 1, 1, 0, 1, 32'h0,   32'h0,   1, 32'h4,   1};
    tbl[2]  = '{0, 1, 1, 0, 1, 32'h0,   32'h4,   1, 32'h8,   1};
    tbl[3]  = '{0, 1, 1, 0, 1, 32'h0,   32'h8,   1, 32'hC,   1};
    tbl[4]  = '{0, 1, 1, 0, 1, 32'h0,   32'hC,   1, 32'h10,  1};
    tbl[5]  = '{0, 0, 0, 0, 1, 32'h0,   32'hC,   1, 32'h10,  0};
    tbl[6]  = '{0, 0, 0, 0, 1, 32'h0,   32'hC,   1, 32'h10,  0};
    tbl[7]  = '{0, 0, 0, 0, 1, 32'h0,   32'hC,   1, 32'h10,  0};
    tbl[8]  = '{0, 1, 1, 0, 1, 32'h0,   32'h10,  1, 32'h14,  1};
    tbl[9]  = '{0, 1, 1, 0, 1, 32'h0,   32'h14,  1, 32'h18,  1};
    tbl[10] = '{0, 1, 1, 0, 1, 32'h0,   32'h18,  1, 32'h1C,  1};
    tbl[11] = '{0, 1, 1, 0, 1, 32'h0,   32'h1C,  1, 32'h20,  1};
    tbl[12] = '{0, 0, 0, 1, 1, 32'h200, 32'h20,  0, 32'h200, 1};
    tbl[13] = '{0, 1, 1, 0, 1, 32'h0,   32'h200, 1, 32'h204, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 32'h0,   32'h200, 1, 32'h204, 0};
    tbl[15] = '{0, 1, 1, 1, 0, 32'h100, 32'h204, 0, 32'h100, 1};
    tbl[16] = '{0, 1, 1, 0, 1, 32'h0,   32'h100, 1, 32'h104, 1};
    tbl[17] = '{0, 1, 1, 0, 0, 32'h0,   32'h104, 0, 32'h104, 1};
    tbl[18] = '{0, 1, 1, 0, 0, 32'h0,   32'h104, 0, 32'h104, 1};
    tbl[19] = '{0, 1, 1, 0, 1, 32'h0,   32'h104, 1, 32'h108, 1};
    tbl[20] = '{0, 0, 1, 0, 0, 32'h0,   32'h104, 1, 32'h108, 1};
    tbl[21] = '{0, 1, 1, 0, 1, 32'h0,   32'h108, 1, 32'h10C, 1};
    tbl[22] = '{0, 1, 0, 0, 1, 32'h0,   32'h108, 1, 32'h10C, 0};
    tbl[23] = '{1, 1, 1, 0, 1, 32'h0,   32'h0,   0, 32'h0,   0};
    tbl[24] = '{0, 1, 1, 0, 1, 32'h0,   32'h0,   1, 32'h4,   1};

    for (int i = 0; i < 25; i++) begin
      cycle(tbl[i].rst, tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].jt, tbl[i].rdy);
      chk($sformatf("tbl%0d_ifid_pc", i), IFID_PC, tbl[i].e_pc);
      chk($sformatf("tbl%0d_valid", i), {31'b0, IFID_Valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_instr", i), IFID_Instr, tbl[i].e_valid ? mem_word(tbl[i].e_pc) : NOP);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
    end

    // PC wrap at the top of the address space.
    cycle(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr_before", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("wrap_ifid_pc", IFID_PC, 32'hFFFF_FFFC);
    chk("wrap_addr_after", imem_addr, 32'h0);

    // Flush while a stall is in HELD, with a response ready in the flush cycle.
    cycle(0, 0, 0, 0, 32'h0, 1);
    chk("held_req", {31'b0, imem_req}, 32'h0);
    cycle(0, 0, 0, 1, 32'h40, 1);
    chk("flush_held_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("flush_held_addr", imem_addr, 32'h40);
    cycle(0, 1, 1, 0, 32'h0, 1);
    chk("flush_held_next", IFID_PC, 32'h40);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] jt;
      jt = $urandom;
      jt[1:0] = 2'b00;
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, jt, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), used as the IF/ID bubble.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 PCWrite  in  1  hazard unit; 0 = hold PC.
REQ-006 IFIDWrite  in  1  hazard unit; 0 = hold IF/ID register.
REQ-007 Flush  in  1  hazard unit; 1 = discard fetched/in-flight instruction and redirect.
REQ-008 jump_target  in  32  redirect PC, sampled when Flush=1.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 imem_addr  out  32  fetch address; always equals the current PC.
REQ-011 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  in  1  memory completes the request this cycle.
REQ-013 IFID_PC  out  32  PC of the instruction in IF/ID.
REQ-014 IFID_Instr  out  32  instruction in IF/ID.
REQ-015 IFID_Valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-016 stall_count, flush_count  out  32 each  performance counters (see Configuration).

Function
REQ-017 stall SHALL be defined as !(PCWrite && IFIDWrite); Flush SHALL take priority over stall in every state.
REQ-018 The FSM SHALL have the states REQ and HELD.
REQ-019 REQ: imem_req=1. On imem_ready && !stall && !Flush: IF/ID <= {PC, imem_rdata, 1}, PC <= PC+4 (mod 2^32), stay in REQ.
REQ-020 REQ: on imem_ready && stall && !Flush: capture imem_rdata and PC in the hold buffer, go to HELD, leave IF/ID and PC unchanged.
REQ-021 REQ: on !imem_ready && !stall && !Flush: IF/ID <= {PC, NOP_INSTR, 0}, PC unchanged.
REQ-022 REQ: on !imem_ready && stall: IF/ID and PC unchanged.
REQ-023 HELD: imem_req=0. On !stall && !Flush: IF/ID <= {buffer PC, buffer instr, 1}, PC <= PC+4, go to REQ. On stall: hold everything.
REQ-024 Flush in any state, regardless of imem_ready or stall: IF/ID <= {PC, NOP_INSTR, 0}, PC <= jump_target, hold buffer discarded, next state REQ.
REQ-025 A response arriving in the same cycle as Flush SHALL be dropped; the next request SHALL carry the new address in the following cycle.
REQ-026 Fetch latency: with imem_ready held at 1 and no hazards, the instruction at address A SHALL appear in IF/ID one cycle after imem_addr=A; throughput is one instruction per cycle.
REQ-027 The hold buffer SHALL be one entry deep; no instruction is lost or duplicated across any stall length.

Reset
REQ-028 While rst=1: PC=RESET_PC, IFID_PC=0, IFID_Instr=NOP_INSTR, IFID_Valid=0, state=REQ, hold buffer empty, counters=0, imem_req=0.
REQ-029 In the first cycle after rst falls, imem_req=1 and imem_addr=RESET_PC; reset mid-stall or mid-HELD SHALL abandon all state.

Configuration
REQ-030 Macro FETCH_PERF_COUNT_EN defined: stall_count increments each non-reset cycle with stall && !Flush; flush_count increments each cycle with Flush; both wrap 32'hFFFF_FFFF -> 0.
REQ-031 Macro FETCH_PERF_COUNT_EN undefined: the counter ports SHALL exist and be driven constant 0, with no counter registers inferred.

Structure
REQ-032 Shared package rv32i_pkg SHALL hold XLEN=32, NOP_INSTR value, the RESET_PC default and the fetch FSM state encoding.
REQ-033 The IF/ID register with load/hold/bubble controls SHALL be one sub-module, ifid_reg; PC, FSM, hold buffer and counters stay in fetch_stage.

Verification
REQ-034 Reset, imem_ready=1 always, no hazards -> IFID_PC sequence 0x0,0x4,0x8 on consecutive cycles, IFID_Valid=1 from second post-reset cycle.
REQ-035 Stall 3 cycles (PCWrite=IFIDWrite=0) while imem_ready=1 at PC 0x10 -> state HELD, imem_req=0, IF/ID frozen; after release IFID_PC=0x10 exactly once, next is 0x14.
REQ-036 Flush with jump_target=0x100 while in HELD -> buffered word dropped, IFID_Valid=0 next cycle, imem_addr=0x100, following IFID_PC=0x100.
REQ-037 Flush and stall asserted together at PC 0x20, imem_ready=1 -> flush behaviour only, PC=target, stall_count unchanged, flush_count+1.
REQ-038 imem_ready=0 for 2 cycles, no stall -> two bubbles (IFID_Instr=0x13, Valid=0), PC unchanged, then normal fetch resumes.
REQ-039 PC=0xFFFF_FFFC, fetch completes -> PC wraps to 0x0; rst asserted during HELD -> REQ-028 values next cycle.
